// File: rtl/rename_map_pkg.sv
// Shared widths and the speculative map-table entry for the 2-wide rename stage.
package rename_map_pkg;

  localparam int ARCH_NUM = 32;
  localparam int ARCH_SEL = 5;
  localparam int PHY_SEL  = 6;
  localparam int ENT_W    = PHY_SEL + 1;

  // busy=0 means the committed value lives in the ARF
  typedef struct packed {
    logic               busy;
    logic [PHY_SEL-1:0] ptag;
  } map_ent_t;

endpackage

// File: rtl/rename_map_deps.sv
// Per-operand source resolver: map entry, same-cycle commit bypass and
// intra-group dependency on slot 1's destination. Purely combinational.
module rename_deps
  import rename_map_pkg::*;
(
  input  logic [ARCH_SEL-1:0] i_rs,
  input  map_ent_t            i_ent,
  input  logic                i_dep_vld,
  input  logic [ARCH_SEL-1:0] i_dep_rd,
  input  logic [PHY_SEL-1:0]  i_dep_tag,
  input  logic                i_com_vld_1,
  input  logic [ARCH_SEL-1:0] i_com_rd_1,
  input  logic [PHY_SEL-1:0]  i_com_ptag_1,
  input  logic                i_com_vld_2,
  input  logic [ARCH_SEL-1:0] i_com_rd_2,
  input  logic [PHY_SEL-1:0]  i_com_ptag_2,
  output map_ent_t            o_src
);

  logic w_byp_1;
  logic w_byp_2;

  assign w_byp_1 = i_com_vld_1 && (i_com_rd_1 == i_rs) && (i_com_ptag_1 == i_ent.ptag);
  assign w_byp_2 = i_com_vld_2 && (i_com_rd_2 == i_rs) && (i_com_ptag_2 == i_ent.ptag);

  always_comb begin
    o_src = i_ent;
    if (w_byp_1 || w_byp_2)
      o_src.busy = 1'b0;
    // a producer earlier in the same group overrides both map and bypass
    if (i_dep_vld && (i_dep_rd == i_rs)) begin
      o_src.busy = 1'b1;
      o_src.ptag = i_dep_tag;
    end
    if (i_rs == '0)
      o_src = '0;
  end

endmodule

// File: rtl/rename_map.sv
// 2-wide rename stage: speculative map table plus RN/DP output latch.
// Commits clear busy bits even while stalled; prmiss drops all busy bits.
module rename_map
  import rename_map_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                prmiss,
  input  logic                invalid1,
  input  logic                invalid2,
  input  logic                wr_1,
  input  logic                wr_2,
  input  logic [ARCH_SEL-1:0] rs1_1,
  input  logic [ARCH_SEL-1:0] rs2_1,
  input  logic [ARCH_SEL-1:0] rd_1,
  input  logic [ARCH_SEL-1:0] rs1_2,
  input  logic [ARCH_SEL-1:0] rs2_2,
  input  logic [ARCH_SEL-1:0] rd_2,
  input  logic [PHY_SEL-1:0]  alloc_1,
  input  logic [PHY_SEL-1:0]  alloc_2,
  input  logic                alloc_valid_1,
  input  logic                alloc_valid_2,
  input  logic                com_valid_1,
  input  logic                com_valid_2,
  input  logic [ARCH_SEL-1:0] com_rd_1,
  input  logic [ARCH_SEL-1:0] com_rd_2,
  input  logic [PHY_SEL-1:0]  com_ptag_1,
  input  logic [PHY_SEL-1:0]  com_ptag_2,
  output logic                out_valid_1,
  output logic                out_valid_2,
  output logic [PHY_SEL-1:0]  prs1_1,
  output logic [PHY_SEL-1:0]  prs2_1,
  output logic [PHY_SEL-1:0]  prs1_2,
  output logic [PHY_SEL-1:0]  prs2_2,
  output logic                busy1_1,
  output logic                busy2_1,
  output logic                busy1_2,
  output logic                busy2_2,
  output logic [PHY_SEL-1:0]  prd_1,
  output logic [PHY_SEL-1:0]  prd_2,
  output logic                wrv_1,
  output logic                wrv_2
);

  map_ent_t r_map [ARCH_NUM];

  logic               w_we_1;
  logic               w_we_2;
  logic [PHY_SEL-1:0] w_tag_1;
  logic [PHY_SEL-1:0] w_tag_2;
  logic [ARCH_NUM-1:0] w_clr;
  map_ent_t           w_s11;
  map_ent_t           w_s21;
  map_ent_t           w_s12;
  map_ent_t           w_s22;
  logic               w_unused;

  // alloc validity is guaranteed upstream via stall; not needed here
  assign w_unused = &{1'b0, alloc_valid_1, alloc_valid_2};

  assign w_we_1  = wr_1 && !invalid1 && (rd_1 != '0);
  assign w_we_2  = wr_2 && !invalid2 && (rd_2 != '0);
  assign w_tag_1 = alloc_1;
  // freelist packs tags: with slot 1 empty, slot 2's tag arrives on alloc_1
  assign w_tag_2 = invalid1 ? alloc_1 : alloc_2;

  always_comb begin
    for (int i = 0; i < ARCH_NUM; i++) begin
      w_clr[i] = r_map[i].busy &&
                 ((com_valid_1 && (com_rd_1 == ARCH_SEL'(i)) && (com_ptag_1 == r_map[i].ptag)) ||
                  (com_valid_2 && (com_rd_2 == ARCH_SEL'(i)) && (com_ptag_2 == r_map[i].ptag)));
    end
  end

  rename_deps u_dep_s11 (
    .i_rs(rs1_1), .i_ent(r_map[rs1_1]), .i_dep_vld(1'b0), .i_dep_rd(rd_1), .i_dep_tag(w_tag_1),
    .i_com_vld_1(com_valid_1), .i_com_rd_1(com_rd_1), .i_com_ptag_1(com_ptag_1),
    .i_com_vld_2(com_valid_2), .i_com_rd_2(com_rd_2), .i_com_ptag_2(com_ptag_2), .o_src(w_s11)
  );
  rename_deps u_dep_s21 (
    .i_rs(rs2_1), .i_ent(r_map[rs2_1]), .i_dep_vld(1'b0), .i_dep_rd(rd_1), .i_dep_tag(w_tag_1),
    .i_com_vld_1(com_valid_1), .i_com_rd_1(com_rd_1), .i_com_ptag_1(com_ptag_1),
    .i_com_vld_2(com_valid_2), .i_com_rd_2(com_rd_2), .i_com_ptag_2(com_ptag_2), .o_src(w_s21)
  );
  rename_deps u_dep_s12 (
    .i_rs(rs1_2), .i_ent(r_map[rs1_2]), .i_dep_vld(w_we_1), .i_dep_rd(rd_1), .i_dep_tag(w_tag_1),
    .i_com_vld_1(com_valid_1), .i_com_rd_1(com_rd_1), .i_com_ptag_1(com_ptag_1),
    .i_com_vld_2(com_valid_2), .i_com_rd_2(com_rd_2), .i_com_ptag_2(com_ptag_2), .o_src(w_s12)
  );
  rename_deps u_dep_s22 (
    .i_rs(rs2_2), .i_ent(r_map[rs2_2]), .i_dep_vld(w_we_1), .i_dep_rd(rd_1), .i_dep_tag(w_tag_1),
    .i_com_vld_1(com_valid_1), .i_com_rd_1(com_rd_1), .i_com_ptag_1(com_ptag_1),
    .i_com_vld_2(com_valid_2), .i_com_rd_2(com_rd_2), .i_com_ptag_2(com_ptag_2), .o_src(w_s22)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_NUM; i++)
        r_map[i] <= '0;
    end else if (prmiss) begin
      for (int i = 0; i < ARCH_NUM; i++)
        r_map[i].busy <= 1'b0;
    end else begin
      for (int i = 0; i < ARCH_NUM; i++) begin
        if (!stall && w_we_2 && (rd_2 == ARCH_SEL'(i)))
          r_map[i] <= '{busy: 1'b1, ptag: w_tag_2};
        else if (!stall && w_we_1 && (rd_1 == ARCH_SEL'(i)))
          r_map[i] <= '{busy: 1'b1, ptag: w_tag_1};
        else if (w_clr[i])
          r_map[i].busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || prmiss) begin
      out_valid_1 <= 1'b0;
      out_valid_2 <= 1'b0;
      prs1_1      <= '0;
      prs2_1      <= '0;
      prs1_2      <= '0;
      prs2_2      <= '0;
      busy1_1     <= 1'b0;
      busy2_1     <= 1'b0;
      busy1_2     <= 1'b0;
      busy2_2     <= 1'b0;
      prd_1       <= '0;
      prd_2       <= '0;
      wrv_1       <= 1'b0;
      wrv_2       <= 1'b0;
    end else if (!stall) begin
      out_valid_1 <= !invalid1;
      out_valid_2 <= !invalid2;
      prs1_1      <= w_s11.ptag;
      prs2_1      <= w_s21.ptag;
      prs1_2      <= w_s12.ptag;
      prs2_2      <= w_s22.ptag;
      busy1_1     <= w_s11.busy;
      busy2_1     <= w_s21.busy;
      busy1_2     <= w_s12.busy;
      busy2_2     <= w_s22.busy;
      prd_1       <= w_we_1 ? w_tag_1 : '0;
      prd_2       <= w_we_2 ? w_tag_2 : '0;
      wrv_1       <= w_we_1;
      wrv_2       <= w_we_2;
    end
  end

endmodule

// File: tb/tb_rename_map.sv
// Bench for rename_map: directed vector table for the corner cases, then
// randomized groups checked against an array-based map model.
module tb_rename_map;
  import rename_map_pkg::*;

  typedef struct packed {
    logic stall, prmiss, inv1, inv2, wr1, wr2;
    logic [4:0] rs11, rs21, rd1, rs12, rs22, rd2;
    logic [5:0] a1, a2;
    logic av1, av2, cv1, cv2;
    logic [4:0] crd1, crd2;
    logic [5:0] cp1, cp2;
  } grp_t;

  typedef struct packed {
    logic ov1, ov2;
    logic [5:0] p11; logic b11;
    logic [5:0] p21; logic b21;
    logic [5:0] p12; logic b12;
    logic [5:0] p22; logic b22;
    logic [5:0] d1;  logic w1;
    logic [5:0] d2;  logic w2;
  } out_t;

  typedef struct packed {
    grp_t g;
    out_t e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, stall, prmiss, invalid1, invalid2, wr_1, wr_2;
  logic [4:0] rs1_1, rs2_1, rd_1, rs1_2, rs2_2, rd_2, com_rd_1, com_rd_2;
  logic [5:0] alloc_1, alloc_2, com_ptag_1, com_ptag_2;
  logic alloc_valid_1, alloc_valid_2, com_valid_1, com_valid_2;
  logic out_valid_1, out_valid_2, busy1_1, busy2_1, busy1_2, busy2_2, wrv_1, wrv_2;
  logic [5:0] prs1_1, prs2_1, prs1_2, prs2_2, prd_1, prd_2;

  rename_map dut (
    .clk(clk), .reset(reset), .stall(stall), .prmiss(prmiss),
    .invalid1(invalid1), .invalid2(invalid2), .wr_1(wr_1), .wr_2(wr_2),
    .rs1_1(rs1_1), .rs2_1(rs2_1), .rd_1(rd_1), .rs1_2(rs1_2), .rs2_2(rs2_2), .rd_2(rd_2),
    .alloc_1(alloc_1), .alloc_2(alloc_2), .alloc_valid_1(alloc_valid_1), .alloc_valid_2(alloc_valid_2),
    .com_valid_1(com_valid_1), .com_valid_2(com_valid_2), .com_rd_1(com_rd_1), .com_rd_2(com_rd_2),
    .com_ptag_1(com_ptag_1), .com_ptag_2(com_ptag_2),
    .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
    .prs1_1(prs1_1), .prs2_1(prs2_1), .prs1_2(prs1_2), .prs2_2(prs2_2),
    .busy1_1(busy1_1), .busy2_1(busy2_1), .busy1_2(busy1_2), .busy2_2(busy2_2),
    .prd_1(prd_1), .prd_2(prd_2), .wrv_1(wrv_1), .wrv_2(wrv_2)
  );

  int checks = 0;
  int failures = 0;

  // reference model: architectural map as plain arrays, plus expected latch
  logic       mb [32];
  logic [5:0] mt [32];
  out_t       m_out;

  function automatic grp_t grp(input logic w1, input logic [4:0] s11, s21, d1,
                               input logic w2, input logic [4:0] s12, s22, d2,
                               input logic [5:0] a1, a2);
    grp_t g;
    g = '0;
    g.wr1 = w1; g.rs11 = s11; g.rs21 = s21; g.rd1 = d1;
    g.wr2 = w2; g.rs12 = s12; g.rs22 = s22; g.rd2 = d2;
    g.a1 = a1; g.a2 = a2; g.av1 = 1'b1; g.av2 = 1'b1;
    return g;
  endfunction

  function automatic out_t ex(input logic ov1, ov2,
                              input logic [5:0] p11, input logic b11, input logic [5:0] p21, input logic b21,
                              input logic [5:0] p12, input logic b12, input logic [5:0] p22, input logic b22,
                              input logic [5:0] d1, input logic w1, input logic [5:0] d2, input logic w2);
    out_t o;
    o.ov1 = ov1; o.ov2 = ov2;
    o.p11 = p11; o.b11 = b11; o.p21 = p21; o.b21 = b21;
    o.p12 = p12; o.b12 = b12; o.p22 = p22; o.b22 = b22;
    o.d1 = d1; o.w1 = w1; o.d2 = d2; o.w2 = w2;
    return o;
  endfunction

  function automatic out_t dut_out();
    return ex(out_valid_1, out_valid_2, prs1_1, busy1_1, prs2_1, busy2_1,
              prs1_2, busy1_2, prs2_2, busy2_2, prd_1, wrv_1, prd_2, wrv_2);
  endfunction

  task automatic drive(input grp_t g);
    logic we1, we2;
    stall = g.stall; prmiss = g.prmiss; invalid1 = g.inv1; invalid2 = g.inv2;
    wr_1 = g.wr1; wr_2 = g.wr2;
    rs1_1 = g.rs11; rs2_1 = g.rs21; rd_1 = g.rd1; rs1_2 = g.rs12; rs2_2 = g.rs22; rd_2 = g.rd2;
    alloc_1 = g.a1; alloc_2 = g.a2; alloc_valid_1 = g.av1; alloc_valid_2 = g.av2;
    com_valid_1 = g.cv1; com_valid_2 = g.cv2; com_rd_1 = g.crd1; com_rd_2 = g.crd2;
    com_ptag_1 = g.cp1; com_ptag_2 = g.cp2;
    we1 = g.wr1 && !g.inv1 && (g.rd1 != 0);
    we2 = g.wr2 && !g.inv2 && (g.rd2 != 0);
    // a write that the freelist cannot supply must be held by stall
    if (!reset && !g.stall && !g.prmiss &&
        ((we1 && !g.av1) || (we2 && !(g.inv1 ? g.av1 : g.av2)))) begin
      failures++;
      $display("FAIL alloc_guard: write without valid tag got=unstalled want=stall");
    end
  endtask

  task automatic check(input string nm, input out_t e);
    out_t a;
    a = dut_out();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  function automatic logic [6:0] mlook(input grp_t g, input logic [4:0] rs, input logic slot2);
    logic b;
    logic [5:0] t;
    if (rs == 0) return 7'd0;
    if (slot2 && g.wr1 && !g.inv1 && g.rd1 != 0 && g.rd1 == rs) return {1'b1, g.a1};
    b = mb[rs];
    t = mt[rs];
    if ((g.cv1 && g.crd1 == rs && g.cp1 == t) || (g.cv2 && g.crd2 == rs && g.cp2 == t)) b = 1'b0;
    return {b, t};
  endfunction

  task automatic model_step(input grp_t g);
    logic we1, we2, hit1, hit2;
    logic [5:0] t2;
    logic [6:0] s;
    we1 = g.wr1 && !g.inv1 && (g.rd1 != 0);
    we2 = g.wr2 && !g.inv2 && (g.rd2 != 0);
    t2  = g.inv1 ? g.a1 : g.a2;
    if (g.prmiss) begin
      m_out = '0;
    end else if (!g.stall) begin
      m_out.ov1 = !g.inv1; m_out.ov2 = !g.inv2;
      s = mlook(g, g.rs11, 1'b0); m_out.b11 = s[6]; m_out.p11 = s[5:0];
      s = mlook(g, g.rs21, 1'b0); m_out.b21 = s[6]; m_out.p21 = s[5:0];
      s = mlook(g, g.rs12, 1'b1); m_out.b12 = s[6]; m_out.p12 = s[5:0];
      s = mlook(g, g.rs22, 1'b1); m_out.b22 = s[6]; m_out.p22 = s[5:0];
      m_out.w1 = we1; m_out.d1 = we1 ? g.a1 : 6'd0;
      m_out.w2 = we2; m_out.d2 = we2 ? t2 : 6'd0;
    end
    hit1 = g.cv1 && mb[g.crd1] && mt[g.crd1] == g.cp1;
    hit2 = g.cv2 && mb[g.crd2] && mt[g.crd2] == g.cp2;
    if (hit1) mb[g.crd1] = 1'b0;
    if (hit2) mb[g.crd2] = 1'b0;
    if (!g.stall && !g.prmiss) begin
      if (we1) begin mb[g.rd1] = 1'b1; mt[g.rd1] = g.a1; end
      if (we2) begin mb[g.rd2] = 1'b1; mt[g.rd2] = t2; end
    end
    if (g.prmiss)
      for (int i = 0; i < 32; i++) mb[i] = 1'b0;
  endtask

  vec_t tv [16];

  initial begin
    grp_t g;

    tv[0].g = grp(1, 3, 0, 5, 1, 5, 0, 5, 6'h00, 6'h01);
    tv[0].e = ex(1, 1, 0, 0, 0, 0, 6'h00, 1, 0, 0, 6'h00, 1, 6'h01, 1);
    tv[1].g = grp(0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[1].g.cv1 = 1; tv[1].g.crd1 = 5; tv[1].g.cp1 = 6'h00;
    tv[1].e = ex(1, 1, 6'h01, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[2].g = tv[1].g; tv[2].g.cp1 = 6'h01;
    tv[2].e = ex(1, 1, 6'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[3].g = grp(0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[3].e = tv[2].e;
    tv[4].g = grp(1, 0, 0, 7, 0, 0, 0, 0, 6'h03, 0);
    tv[4].e = ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6'h03, 1, 0, 0);
    tv[5].g = grp(1, 7, 0, 7, 0, 7, 0, 0, 6'h02, 0);
    tv[5].g.cv1 = 1; tv[5].g.crd1 = 7; tv[5].g.cp1 = 6'h03;
    tv[5].e = ex(1, 1, 6'h03, 0, 0, 0, 6'h02, 1, 0, 0, 6'h02, 1, 0, 0);
    tv[6].g = grp(0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[6].e = ex(1, 1, 6'h02, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[7].g = grp(1, 0, 0, 6, 1, 0, 0, 4, 6'h09, 6'h3f);
    tv[7].g.inv1 = 1; tv[7].g.av2 = 0;
    tv[7].e = ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'h09, 1);
    tv[8].g = grp(1, 4, 0, 8, 0, 0, 0, 0, 6'h10, 0);
    tv[8].g.stall = 1; tv[8].g.cv1 = 1; tv[8].g.crd1 = 4; tv[8].g.cp1 = 6'h09;
    tv[8].e = tv[7].e;
    tv[9].g = grp(0, 0, 0, 0, 1, 7, 0, 9, 0, 6'h20);
    tv[9].g.stall = 1; tv[9].g.inv1 = 1;
    tv[9].e = tv[7].e;
    tv[10].g = grp(1, 3, 5, 2, 1, 2, 4, 3, 6'h21, 6'h22);
    tv[10].g.stall = 1; tv[10].g.cv2 = 1; tv[10].g.crd2 = 7; tv[10].g.cp2 = 6'h00;
    tv[10].e = tv[7].e;
    tv[11].g = grp(0, 4, 8, 0, 0, 7, 5, 0, 0, 0);
    tv[11].e = ex(1, 1, 6'h09, 0, 0, 0, 6'h02, 1, 6'h01, 0, 0, 0, 0, 0);
    tv[12].g = grp(1, 0, 0, 10, 1, 0, 0, 11, 6'h11, 6'h12);
    tv[12].e = ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6'h11, 1, 6'h12, 1);
    tv[13].g = grp(1, 10, 11, 12, 1, 7, 0, 13, 6'h13, 6'h14);
    tv[13].g.prmiss = 1;
    tv[13].e = '0;
    tv[14].g = grp(0, 10, 11, 0, 0, 12, 7, 0, 0, 0);
    tv[14].e = ex(1, 1, 6'h11, 0, 6'h12, 0, 0, 0, 6'h02, 0, 0, 0, 0, 0);
    tv[15].g = grp(1, 0, 0, 0, 1, 0, 0, 0, 6'h15, 6'h16);
    tv[15].e = ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    reset = 1'b1;
    drive('0);
    repeat (2) @(posedge clk);
    #1;
    check("reset", '0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(tv[i].g);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tv[i].e);
    end

    // dirty outputs first so the second reset check is meaningful
    reset = 1'b1;
    drive('0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset2", '0);
    for (int i = 0; i < 32; i++) begin mb[i] = 1'b0; mt[i] = 6'd0; end
    m_out = '0;

    for (int n = 0; n < 2000; n++) begin
      logic we1, we2;
      g = '0;
      g.stall  = ($urandom_range(4) == 0);
      g.prmiss = ($urandom_range(39) == 0);
      g.inv1 = ($urandom_range(3) == 0);
      g.inv2 = ($urandom_range(3) == 0);
      g.wr1  = ($urandom_range(3) != 0);
      g.wr2  = ($urandom_range(3) != 0);
      g.rs11 = 5'($urandom_range(7)); g.rs21 = 5'($urandom_range(7)); g.rd1 = 5'($urandom_range(7));
      g.rs12 = 5'($urandom_range(7)); g.rs22 = 5'($urandom_range(7)); g.rd2 = 5'($urandom_range(7));
      g.a1 = 6'($urandom); g.a2 = 6'($urandom);
      g.av1 = ($urandom_range(7) != 0);
      g.av2 = ($urandom_range(7) != 0);
      g.cv1 = $urandom_range(1); g.cv2 = $urandom_range(1);
      g.crd1 = 5'($urandom_range(7)); g.crd2 = 5'($urandom_range(7));
      g.cp1 = $urandom_range(1) ? mt[g.crd1] : 6'($urandom);
      g.cp2 = $urandom_range(1) ? mt[g.crd2] : 6'($urandom);
      we1 = g.wr1 && !g.inv1 && (g.rd1 != 0);
      we2 = g.wr2 && !g.inv2 && (g.rd2 != 0);
      if ((we1 && !g.av1) || (we2 && !(g.inv1 ? g.av1 : g.av2)))
        g.stall = 1'b1;
      drive(g);
      model_step(g);
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", n), m_out);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
